multi_cycle_ctrl_fsm: RTL and testbench

MULTI_CYCLE_CTRL_FSM -- requirements
Module: multi_cycle_ctrl_fsm

---
 rtl/multi_cycle_ctrl_fsm.sv | 176 +++++++++++++++++
 tb/tb_multi_cycle_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl_fsm.sv
// ============================================================================
// multi_cycle_ctrl_fsm : control FSM for a multi-cycle RV32I-style datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_cycle_ctrl_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       bcond,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_ctrl_op,
   output logic       halted,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_BT   = 3'd5,
      ST_HALT = 3'd7
   } state_t;

   localparam logic [6:0] c_op_rtype  = 7'b0110011;
   localparam logic [6:0] c_op_iarith = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_ecall  = 7'b1110011;

   state_t     state_q, state_d;
   logic [1:0] ex_a, ex_b, ex_op;
   logic       is_load, is_store;

   // ALU operand/op selection used in EX and held through MEM and WB
   always_comb begin
      ex_a     = 2'b00;
      ex_b     = 2'b00;
      ex_op    = 2'b00;
      is_load  = (opcode == c_op_load);
      is_store = (opcode == c_op_store);
      case (opcode)
         c_op_rtype:  begin ex_a = 2'b10; ex_b = 2'b00; ex_op = 2'b10; end
         c_op_iarith: begin ex_a = 2'b10; ex_b = 2'b10; ex_op = 2'b10; end
         c_op_load,
         c_op_store:  begin ex_a = 2'b10; ex_b = 2'b10; ex_op = 2'b00; end
         c_op_branch: begin ex_a = 2'b10; ex_b = 2'b00; ex_op = 2'b01; end
         c_op_jal:    begin ex_a = 2'b01; ex_b = 2'b10; ex_op = 2'b11; end
         c_op_jalr:   begin ex_a = 2'b10; ex_b = 2'b10; ex_op = 2'b11; end
         default:     begin ex_a = 2'b00; ex_b = 2'b00; ex_op = 2'b00; end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_ctrl_op = 2'b00;
      halted      = 1'b0;

      case (state_q)
         ST_IF: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_ID;
            end
         end
         ST_ID: begin
            state_d = (opcode == c_op_ecall) ? ST_HALT : ST_EX;
         end
         ST_EX: begin
            alu_src_a   = ex_a;
            alu_src_b   = ex_b;
            alu_ctrl_op = ex_op;
            case (opcode)
               c_op_rtype, c_op_iarith: state_d = ST_WB;
               c_op_load, c_op_store:   state_d = ST_MEM;
               c_op_branch:             state_d = bcond ? ST_BT : ST_IF;
               c_op_jal, c_op_jalr: begin
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  wb_sel    = 2'b10;
                  state_d   = ST_IF;
               end
               default:                 state_d = ST_IF;
            endcase
         end
         ST_MEM: begin
            alu_src_a   = ex_a;
            alu_src_b   = ex_b;
            alu_ctrl_op = ex_op;
            i_or_d      = 1'b1;
            mem_read    = is_load;
            mem_write   = is_store;
            if (mem_ready) begin
               state_d = is_load ? ST_WB : ST_IF;
            end
         end
         ST_WB: begin
            alu_src_a   = ex_a;
            alu_src_b   = ex_b;
            alu_ctrl_op = ex_op;
            reg_write   = 1'b1;
            wb_sel      = is_load ? 2'b01 : 2'b00;
            state_d     = ST_IF;
         end
         ST_BT: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = ST_IF;
         end
         ST_HALT: begin
            halted  = 1'b1;
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IF;
         end
      endcase

      // Reset is combinationally folded in so an in-flight access drops at once
      if (!reset) begin
         state_d     = ST_IF;
         pc_write    = 1'b0;
         ir_write    = 1'b0;
         i_or_d      = 1'b0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         reg_write   = 1'b0;
         wb_sel      = 2'b00;
         alu_src_a   = 2'b00;
         alu_src_b   = 2'b00;
         alu_ctrl_op = 2'b00;
         halted      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IF;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// ============================================================================
// tb_multi_cycle_ctrl_fsm : directed self-checking bench for multi_cycle_ctrl_fsm
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_cycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       bcond;
   logic       mem_ready;
   logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
   logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_ctrl_op;
   logic       halted;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   multi_cycle_ctrl_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .bcond       (bcond),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .i_or_d      (i_or_d),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .wb_sel      (wb_sel),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_ctrl_op (alu_ctrl_op),
      .halted      (halted),
      .state       (state)
   );

   always #5 clk = ~clk;

   // {halted, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, wb_sel, a, b, op}
   logic [14:0] ctl;
   assign ctl = {halted, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                 wb_sel, alu_src_a, alu_src_b, alu_ctrl_op};

   function automatic logic [14:0] mk(input logic h, input logic pcw, input logic irw,
                                      input logic iod, input logic mr, input logic mw,
                                      input logic rw, input logic [1:0] wb,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op);
      return {h, pcw, irw, iod, mr, mw, rw, wb, a, b, op};
   endfunction

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_EC   = 7'b1110011;

   // Hand-computed control words
   localparam logic [14:0] E_ZERO  = 15'd0;
   localparam logic [14:0] E_IFW   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00};
   localparam logic [14:0] E_IFG   = {1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00};
   localparam logic [14:0] E_EXR   = {7'b0000000,2'b00,2'b10,2'b00,2'b10};
   localparam logic [14:0] E_WBR   = {7'b0000001,2'b00,2'b10,2'b00,2'b10};
   localparam logic [14:0] E_EXI   = {7'b0000000,2'b00,2'b10,2'b10,2'b10};
   localparam logic [14:0] E_WBI   = {7'b0000001,2'b00,2'b10,2'b10,2'b10};
   localparam logic [14:0] E_EXLS  = {7'b0000000,2'b00,2'b10,2'b10,2'b00};
   localparam logic [14:0] E_MEML  = {7'b0001100,2'b00,2'b10,2'b10,2'b00};
   localparam logic [14:0] E_MEMS  = {7'b0001010,2'b00,2'b10,2'b10,2'b00};
   localparam logic [14:0] E_WBL   = {7'b0000001,2'b01,2'b10,2'b10,2'b00};
   localparam logic [14:0] E_EXB   = {7'b0000000,2'b00,2'b10,2'b00,2'b01};
   localparam logic [14:0] E_BT    = {7'b0100000,2'b00,2'b01,2'b10,2'b00};
   localparam logic [14:0] E_EXJR  = {7'b0100001,2'b10,2'b10,2'b10,2'b11};
   localparam logic [14:0] E_EXJ   = {7'b0100001,2'b10,2'b01,2'b10,2'b11};
   localparam logic [14:0] E_HALT  = {7'b1000000,2'b00,2'b00,2'b00,2'b00};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Check state and control word now, then advance to #1 after the next edge
   task automatic cyc(input string tag, input logic [2:0] exp_st, input logic [14:0] exp_ctl);
      #1;
      check({tag, "_st"},  {29'd0, state}, {29'd0, exp_st});
      check({tag, "_ctl"}, {17'd0, ctl},   {17'd0, exp_ctl});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      opcode    = OP_R;
      bcond     = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_st",  {29'd0, state}, 32'd0);
      check("rst_ctl", {17'd0, ctl},   {17'd0, E_ZERO});
      reset = 1'b1;

      // ADD: 0,1,2,4
      opcode = OP_R;
      cyc("add_if", 3'd0, E_IFG);
      cyc("add_id", 3'd1, E_ZERO);
      cyc("add_ex", 3'd2, E_EXR);
      cyc("add_wb", 3'd4, E_WBR);

      // ADDI
      opcode = OP_I;
      cyc("addi_if", 3'd0, E_IFG);
      cyc("addi_id", 3'd1, E_ZERO);
      cyc("addi_ex", 3'd2, E_EXI);
      cyc("addi_wb", 3'd4, E_WBI);

      // LW with two wait cycles in IF and in MEM: 9 cycles
      opcode = OP_LD;
      mem_ready = 1'b0;
      cyc("lw_ifw0", 3'd0, E_IFW);
      cyc("lw_ifw1", 3'd0, E_IFW);
      mem_ready = 1'b1;
      cyc("lw_if",   3'd0, E_IFG);
      cyc("lw_id",   3'd1, E_ZERO);
      cyc("lw_ex",   3'd2, E_EXLS);
      mem_ready = 1'b0;
      cyc("lw_memw0", 3'd3, E_MEML);
      cyc("lw_memw1", 3'd3, E_MEML);
      mem_ready = 1'b1;
      cyc("lw_mem",  3'd3, E_MEML);
      cyc("lw_wb",   3'd4, E_WBL);

      // BEQ taken: 0,1,2,5
      opcode = OP_BR;
      bcond  = 1'b1;
      cyc("beqt_if", 3'd0, E_IFG);
      cyc("beqt_id", 3'd1, E_ZERO);
      cyc("beqt_ex", 3'd2, E_EXB);
      cyc("beqt_bt", 3'd5, E_BT);

      // BEQ not taken: 0,1,2
      bcond = 1'b0;
      cyc("beqn_if", 3'd0, E_IFG);
      cyc("beqn_id", 3'd1, E_ZERO);
      cyc("beqn_ex", 3'd2, E_EXB);

      // JALR and JAL
      opcode = OP_JALR;
      cyc("jalr_if", 3'd0, E_IFG);
      cyc("jalr_id", 3'd1, E_ZERO);
      cyc("jalr_ex", 3'd2, E_EXJR);
      opcode = OP_JAL;
      cyc("jal_if", 3'd0, E_IFG);
      cyc("jal_id", 3'd1, E_ZERO);
      cyc("jal_ex", 3'd2, E_EXJ);

      // Unknown opcode behaves as NOP
      opcode = 7'b0000000;
      cyc("nop_if", 3'd0, E_IFG);
      cyc("nop_id", 3'd1, E_ZERO);
      cyc("nop_ex", 3'd2, E_ZERO);

      // Store completing normally: 0,1,2,3
      opcode = OP_ST;
      cyc("sw_if",  3'd0, E_IFG);
      cyc("sw_id",  3'd1, E_ZERO);
      cyc("sw_ex",  3'd2, E_EXLS);
      cyc("sw_mem", 3'd3, E_MEMS);

      // Store stalled in MEM, reset mid-cycle
      cyc("swr_if", 3'd0, E_IFG);
      cyc("swr_id", 3'd1, E_ZERO);
      cyc("swr_ex", 3'd2, E_EXLS);
      mem_ready = 1'b0;
      #1;
      check("swr_mem_st",  {29'd0, state}, 32'd3);
      check("swr_mem_ctl", {17'd0, ctl},   {17'd0, E_MEMS});
      #2;
      reset = 1'b0;
      #1;
      check("swr_rst_st",  {29'd0, state}, 32'd0);
      check("swr_rst_ctl", {17'd0, ctl},   {17'd0, E_ZERO});
      @(posedge clk);
      #1;
      check("swr_rsth_ctl", {17'd0, ctl}, {17'd0, E_ZERO});
      reset = 1'b1;
      cyc("swr_rel", 3'd0, E_IFW);

      // ECALL: halt after ID, sticky under arbitrary inputs
      mem_ready = 1'b1;
      opcode    = OP_EC;
      cyc("ec_if", 3'd0, E_IFG);
      cyc("ec_id", 3'd1, E_ZERO);
      for (int i = 0; i < 10; i++) begin
         opcode    = 7'($urandom);
         bcond     = 1'($urandom);
         mem_ready = 1'($urandom);
         cyc($sformatf("halt%0d", i), 3'd7, E_HALT);
      end
      reset = 1'b0;
      #1;
      check("halt_rst_st",  {29'd0, state}, 32'd0);
      check("halt_rst_ctl", {17'd0, ctl},   {17'd0, E_ZERO});
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      opcode    = OP_R;
      reset     = 1'b1;
      cyc("post_if", 3'd0, E_IFG);
      cyc("post_id", 3'd1, E_ZERO);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
